// File: rtl/alu_pipe.sv
// Registered ALU with valid/ready handshakes, tag pass-through and an iterative shift-add multiplier.
// Optional flag output {N,Z,C,V} is enabled by defining ALU_FLAGS_EN.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] input_a,
  input  logic [WIDTH-1:0] input_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic [TAG_W-1:0] out_tag
`ifdef ALU_FLAGS_EN
  ,
  output logic [3:0]       out_flags
`endif
);

  localparam int SHW = $clog2(WIDTH);
  localparam int CW  = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_AND  = 4'b0010;
  localparam logic [3:0] OP_OR   = 4'b0011;
  localparam logic [3:0] OP_EPAR = 4'b0100;
  localparam logic [3:0] OP_XOR  = 4'b0101;
  localparam logic [3:0] OP_SHL  = 4'b0110;
  localparam logic [3:0] OP_SHR  = 4'b0111;
  localparam logic [3:0] OP_MUL  = 4'b1000;

  typedef enum logic {
    IDLE = 1'b0,
    MUL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_stateNext;
  logic             w_inReady;
  logic             w_accept;
  logic             w_mulDone;
  logic             w_writeAlu;
  logic             w_writeMul;

  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_count;
  logic [TAG_W-1:0] r_mulTag;
  logic [WIDTH-1:0] w_accNext;

  logic [WIDTH-1:0] r_out;
  logic [TAG_W-1:0] r_outTag;
  logic             r_outValid;

  logic [SHW-1:0]   w_shamt;
  logic [WIDTH-1:0] w_result;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // A new operation is only taken when idle and the output register is empty or draining now.
  always_comb begin
    w_stateNext = r_state;
    w_inReady   = 1'b0;
    w_mulDone   = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = !r_outValid || out_ready;
        if (in_valid && w_inReady && (op == OP_MUL)) begin
          w_stateNext = MUL;
        end
      end
      MUL: begin
        if (r_count == '0) begin
          w_mulDone   = 1'b1;
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  assign w_accept   = in_valid && w_inReady;
  assign w_writeAlu = w_accept && (op != OP_MUL);
  assign w_writeMul = w_mulDone;

  assign w_shamt = input_b[SHW-1:0];

  always_comb begin
    w_result = '0;
    case (op)
      OP_ADD:  w_result = input_a + input_b;
      OP_SUB:  w_result = input_a - input_b;
      OP_AND:  w_result = input_a & input_b;
      OP_OR:   w_result = input_a | input_b;
      OP_EPAR: w_result = {{(WIDTH-1){1'b0}}, ^input_a};
      OP_XOR:  w_result = input_a ^ input_b;
      OP_SHL:  w_result = input_a << w_shamt;
      OP_SHR:  w_result = input_a >> w_shamt;
      default: w_result = '0;
    endcase
  end

  // The final iteration's partial sum is written straight to the output, so no extra cycle is spent.
  assign w_accNext = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_count  <= '0;
      r_mulTag <= '0;
    end else if (w_accept && (op == OP_MUL)) begin
      r_mcand  <= input_a;
      r_mplier <= input_b;
      r_acc    <= '0;
      r_count  <= CW'(WIDTH - 1);
      r_mulTag <= in_tag;
    end else if (r_state == MUL) begin
      r_acc    <= w_accNext;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (r_count != '0) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

  // A fresh write wins over a drain, keeping out_valid high for back-to-back results.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out      <= '0;
      r_outTag   <= '0;
      r_outValid <= 1'b0;
    end else if (w_writeAlu) begin
      r_out      <= w_result;
      r_outTag   <= in_tag;
      r_outValid <= 1'b1;
    end else if (w_writeMul) begin
      r_out      <= w_accNext;
      r_outTag   <= r_mulTag;
      r_outValid <= 1'b1;
    end else if (out_ready) begin
      r_outValid <= 1'b0;
    end
  end

  assign in_ready  = w_inReady;
  assign out       = r_out;
  assign out_tag   = r_outTag;
  assign out_valid = r_outValid;

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0]   w_sumWide;
  logic [WIDTH-1:0] w_diff;
  logic [3:0]       w_flagsAlu;
  logic [3:0]       w_flagsMul;
  logic [3:0]       r_flags;

  assign w_sumWide = {1'b0, input_a} + {1'b0, input_b};
  assign w_diff    = input_a - input_b;

  // C is carry for add and unsigned borrow for sub; V is two's-complement overflow.
  always_comb begin
    w_flagsAlu    = 4'b0000;
    w_flagsAlu[3] = w_result[WIDTH-1];
    w_flagsAlu[2] = (w_result == '0);
    case (op)
      OP_ADD: begin
        w_flagsAlu[1] = w_sumWide[WIDTH];
        w_flagsAlu[0] = (input_a[WIDTH-1] == input_b[WIDTH-1]) &&
                        (w_sumWide[WIDTH-1] != input_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_flagsAlu[1] = (input_a < input_b);
        w_flagsAlu[0] = (input_a[WIDTH-1] != input_b[WIDTH-1]) &&
                        (w_diff[WIDTH-1] != input_a[WIDTH-1]);
      end
      default: begin
        w_flagsAlu[1] = 1'b0;
        w_flagsAlu[0] = 1'b0;
      end
    endcase
  end

  assign w_flagsMul = {w_accNext[WIDTH-1], (w_accNext == '0), 2'b00};

  always_ff @(posedge clock) begin
    if (reset) begin
      r_flags <= 4'b0000;
    end else if (w_writeAlu) begin
      r_flags <= w_flagsAlu;
    end else if (w_writeMul) begin
      r_flags <= w_flagsMul;
    end
  end

  assign out_flags = r_flags;
`endif

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the 16-bit combinational ALU. It supports any WIDTH and adds XOR, logical shifts, and an iterative shift-add multiplier. Operands enter through a valid/ready handshake and results leave through one. An opaque tag travels with each operation so the issuing datapath can match results to requests.

Parameters:
WIDTH, 16, operand/result width in bits; legal values are 4 and above.
TAG_W, 4, width of the pass-through tag; legal values are 1 and above.

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  operation presented
in_ready  output  1  block can accept an operation this cycle
op  input  4  opcode (see Behaviour)
input_a  input  WIDTH  operand A
input_b  input  WIDTH  operand B
in_tag  input  TAG_W  request tag
out_valid  output  1  result presented
out_ready  input  1  consumer accepts the result
out  output  WIDTH  result
out_tag  output  TAG_W  tag of the operation that produced out

Behaviour:
- Accept: an operation is accepted on an edge where in_valid && in_ready. Operands, op and tag are captured at that edge.
- in_ready (combinational) = (state==IDLE) && (!out_valid || out_ready). This allows back-to-back issue when the consumer drains in the same cycle.
- Opcodes (all arithmetic is modulo 2^WIDTH; no exceptions):
  - 0000 add: a+b
  - 0001 sub: a-b
  - 0010 and
  - 0011 or
  - 0100 epar: XOR-reduce of a, zero-extended (1 when a has an odd number of ones)
  - 0101 xor
  - 0110 shl: a << b[clog2(WIDTH)-1:0]; upper bits of b ignored
  - 0111 shr: logical right shift, same amount rule as shl
  - 1000 mul: low WIDTH bits of a*b
  - 1001-1111: result 0
- Latency:
  - Every non-mul op: out/out_tag registered at the accepting edge; out_valid=1 in the next cycle (latency 1).
  - mul: latency WIDTH+1 cycles, out_valid rising at the (WIDTH+1)th edge after acceptance.
- FSM:
  - IDLE: on accept of mul go to MUL, load multiplicand/multiplier, clear accumulator, counter=WIDTH-1; other ops stay in IDLE.
  - MUL: one shift-add iteration per edge; in_ready=0. When the counter reaches 0, write out, set out_valid, go to IDLE.
  - A mul finishing while a prior result is still unconsumed cannot occur: accept requires the output register to be free or draining.
- Output hold: while out_valid && !out_ready, out and out_tag stay stable. out_valid clears on an edge with out_ready=1 unless a new result is written on that same edge; a new write takes precedence and keeps out_valid=1.
- Reset (synchronous, any state including mid-MUL): state=IDLE, out_valid=0, out=0, out_tag=0, accumulator and counter cleared. In-flight work is discarded with no result produced. in_ready=1 in the first cycle after reset deasserts.
- in_valid while in_ready=0: not accepted. The source must hold its inputs until accepted.

Optional Feature:
ALU_FLAGS_EN
- Defined: adds output port out_flags (4 bits) = {N, Z, C, V}, registered with out and held the same way as out. Reset value 0.
  - N = out[WIDTH-1]
  - Z = (out==0)
  - C = carry-out for add, borrow (a<b unsigned) for sub, 0 otherwise
  - V = signed overflow for add/sub, 0 otherwise
- Undefined: out_flags port and all flag logic are absent. All other behaviour is identical.

Test Plan:
1. WIDTH=16: reset, then add 0x7FFF + 0x0001 with tag 3. Required: out=0x8000, out_tag=3, out_valid one cycle after accept. With flags: N=1, Z=0, C=0, V=1.
2. sub 0x0000 - 0x0001. Required: out=0xFFFF. With flags: C=1, V=0.
3. epar a=0x0007 -> out=0x0001; epar a=0x8421 -> out=0x0000. Then shl a=0x0001, b=0x0013 -> out=0x0008 (b masked to 3).
4. mul 0x0123 * 0x0010 -> out=0x1230, out_valid exactly 17 cycles after accept. mul 0xFFFF * 0xFFFF -> out=0x0001. in_ready=0 throughout both.
5. Backpressure:
   - Issue add, then hold out_ready=0 for 5 cycles. Required: out stable, in_ready=0.
   - Then raise out_ready with in_valid=1 (xor 0x00FF, 0x0F0F). Required: accepted that edge, next cycle out=0x0FF0 with out_valid still 1.
6. Assert reset on the 5th cycle of a mul. Required: out_valid never asserts for it, out=0, in_ready=1 after reset. A following and 0xF0F0, 0xFF00 gives 0xF000.
